// File: rtl/event_arbiter_if.sv
// Record-stream bundle between NUM_SRC event sources, the arbiter and the single log sink.
// master = arbiter side (drives src_ready and the evt_* stream); slave = environment side.
interface event_arbiter_if #(
  parameter int NUM_SRC   = 4,
  parameter int PAYLOAD_W = 32,
  parameter int TS_W      = 32,
  parameter int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) ();
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC-1:0]           src_ready;
  logic [3*NUM_SRC-1:0]         src_level;
  logic [PAYLOAD_W*NUM_SRC-1:0] src_payload;
  logic                         evt_valid;
  logic                         evt_ready;
  logic [SRC_W-1:0]             evt_src;
  logic [2:0]                   evt_level;
  logic [PAYLOAD_W-1:0]         evt_payload;
  logic [TS_W-1:0]              evt_time;

  modport master (
    input  src_valid, src_level, src_payload, evt_ready,
    output src_ready, evt_valid, evt_src, evt_level, evt_payload, evt_time
  );

  modport slave (
    output src_valid, src_level, src_payload, evt_ready,
    input  src_ready, evt_valid, evt_src, evt_level, evt_payload, evt_time
  );
endinterface

// File: rtl/event_arbiter.sv
// Round-robin serialiser of per-source event records onto one log stream; capture->present in 2 edges,
// evt_* held stable under evt_ready=0, src_ready=~held. EVENT_ARBITER_LEVEL_FILTER_EN adds min_level drop filter.
module event_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int PAYLOAD_W = 32,
  parameter int TS_W      = 32,
  parameter int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  event_arbiter_if.master bus,
  output logic [15:0]     err_count,
  output logic            fatal
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
  ,
  input  logic [2:0]      min_level,
  output logic [15:0]     drop_count
`endif
);

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t               state_q, state_d;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [NUM_SRC-1:0]   held_q, held_d;
  logic [SRC_W-1:0]     rr_q, rr_d;
  logic [2:0]           hold_level_q   [NUM_SRC];
  logic [2:0]           hold_level_d   [NUM_SRC];
  logic [PAYLOAD_W-1:0] hold_payload_q [NUM_SRC];
  logic [PAYLOAD_W-1:0] hold_payload_d [NUM_SRC];
  logic [TS_W-1:0]      hold_time_q    [NUM_SRC];
  logic [TS_W-1:0]      hold_time_d    [NUM_SRC];

  logic                 evt_valid_q, evt_valid_d;
  logic [SRC_W-1:0]     evt_src_q, evt_src_d;
  logic [2:0]           evt_level_q, evt_level_d;
  logic [PAYLOAD_W-1:0] evt_payload_q, evt_payload_d;
  logic [TS_W-1:0]      evt_time_q, evt_time_d;
  logic [15:0]          err_count_q, err_count_d;
  logic                 fatal_q, fatal_d;

  logic                 win_vld;
  logic [SRC_W-1:0]     win_idx;
  logic                 load;
  logic                 hs;

`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
  logic [15:0]          drop_count_q, drop_count_d;
  logic [4:0]           drop_inc;
  logic [16:0]          drop_sum;
`endif

  // Round-robin search over the registered held[] vector, starting just after the last winner.
  always_comb begin : arb_c
    int cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!win_vld && held_q[cand]) begin
        win_vld = 1'b1;
        win_idx = SRC_W'(cand);
      end
    end
  end

  assign hs   = evt_valid_q && bus.evt_ready;
  assign load = win_vld && (!evt_valid_q || bus.evt_ready);

  always_comb begin : capture_c
    logic [2:0] lvl;
    lvl    = '0;
    held_d = held_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_level_d[i]   = hold_level_q[i];
      hold_payload_d[i] = hold_payload_q[i];
      hold_time_d[i]    = hold_time_q[i];
    end
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
    drop_inc = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      lvl = bus.src_level[3*i +: 3];
      if (bus.src_valid[i] && !held_q[i]) begin
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
        if (lvl < min_level) begin
          drop_inc = drop_inc + 5'd1;
        end else begin
`else
        begin
`endif
          held_d[i]         = 1'b1;
          hold_level_d[i]   = (lvl > 3'd5) ? 3'd4 : lvl;
          hold_payload_d[i] = bus.src_payload[PAYLOAD_W*i +: PAYLOAD_W];
          hold_time_d[i]    = ts_q;
        end
      end
    end
    // A capture needs !held_q and a load needs held_q, so the two never touch the same bit.
    if (load) held_d[win_idx] = 1'b0;
  end

  always_comb begin : out_c
    state_d       = state_q;
    rr_d          = rr_q;
    evt_src_d     = evt_src_q;
    evt_level_d   = evt_level_q;
    evt_payload_d = evt_payload_q;
    evt_time_d    = evt_time_q;
    case (state_q)
      ST_IDLE:    if (win_vld) state_d = ST_PRESENT;
      ST_PRESENT: if (hs) state_d = win_vld ? ST_PRESENT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (load) begin
      rr_d          = win_idx;
      evt_src_d     = win_idx;
      evt_level_d   = hold_level_q[win_idx];
      evt_payload_d = hold_payload_q[win_idx];
      evt_time_d    = hold_time_q[win_idx];
    end
    evt_valid_d = (state_d == ST_PRESENT);
  end

  always_comb begin : status_c
    ts_d        = ts_q + TS_W'(1);
    err_count_d = err_count_q;
    if (hs && (evt_level_q >= 3'd4) && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
    fatal_d = fatal_q | (hs && (evt_level_q == 3'd5));
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
    drop_sum     = {1'b0, drop_count_q} + {12'd0, drop_inc};
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ts_q          <= '0;
      held_q        <= '0;
      rr_q          <= SRC_W'(NUM_SRC - 1);
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_level_q[i]   <= '0;
        hold_payload_q[i] <= '0;
        hold_time_q[i]    <= '0;
      end
      evt_valid_q   <= 1'b0;
      evt_src_q     <= '0;
      evt_level_q   <= '0;
      evt_payload_q <= '0;
      evt_time_q    <= '0;
      err_count_q   <= '0;
      fatal_q       <= 1'b0;
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
      drop_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      held_q        <= held_d;
      rr_q          <= rr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_level_q[i]   <= hold_level_d[i];
        hold_payload_q[i] <= hold_payload_d[i];
        hold_time_q[i]    <= hold_time_d[i];
      end
      evt_valid_q   <= evt_valid_d;
      evt_src_q     <= evt_src_d;
      evt_level_q   <= evt_level_d;
      evt_payload_q <= evt_payload_d;
      evt_time_q    <= evt_time_d;
      err_count_q   <= err_count_d;
      fatal_q       <= fatal_d;
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
      drop_count_q  <= drop_count_d;
`endif
    end
  end

  assign bus.src_ready   = ~held_q;
  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_src     = evt_src_q;
  assign bus.evt_level   = evt_level_q;
  assign bus.evt_payload = evt_payload_q;
  assign bus.evt_time    = evt_time_q;
  assign err_count       = err_count_q;
  assign fatal           = fatal_q;
`ifdef EVENT_ARBITER_LEVEL_FILTER_EN
  assign drop_count      = drop_count_q;
`endif

endmodule
